dmem_responder: RTL

Data-memory responder at the far end of the pipelined CPU's load/store interface. Serves memread/memwrite requests from the EX/MEM stage against an internal word array that models slow memory.
- Reads take a programmable number of wait states; mem_stall is raised so the pipeline holds the request stable.
- Stores are posted into a one-entry write buffer and never stall.
- Loads that hit the buffered store are forwarded from it with zero wait.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-stated array reads, one-entry posted write buffer, store-to-load forwarding.
// Optional misaligned-access trap is built when DMEM_MISALIGN_TRAP_EN is defined.
module dmem_responder #(
    parameter int ADDR_W    = 8,
    parameter int READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        mem_stall,
    output logic        wb_pending
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

    localparam logic [3:0] WAIT_INIT = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic              mem_we;
    logic              rd_en;
    logic              stall_c;
    logic [31:0]       rdata_out;
    logic              unused_addr_bits;

    assign idx              = memaddr[ADDR_W+1:2];
    assign hit              = wb_valid_q && (wb_addr_q == idx);
    assign unused_addr_bits = ^{memaddr[31:ADDR_W+2], memaddr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_req;
    logic misaligned_q, misaligned_d;
    assign mis_req    = (memread || memwrite) && (memaddr[1:0] != 2'b00);
    assign misaligned = misaligned_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        stall_c    = 1'b0;
        rdata_out  = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                if (mis_req) begin
                    // request is dropped; the buffer still drains like any idle cycle
                    misaligned_d = 1'b1;
                    if (memread) rdata_out = '0;
                    mem_we     = wb_valid_q;
                    wb_valid_d = 1'b0;
                end else
`endif
                if (memwrite) begin
                    mem_we     = wb_valid_q;
                    wb_valid_d = 1'b1;
                    wb_addr_d  = idx;
                    wb_data_d  = memwritedata;
                end else if (memread && hit) begin
                    rdata_out  = wb_data_q;
                    mem_we     = 1'b1;
                    wb_valid_d = 1'b0;
                end else if (memread) begin
                    // buffer is held across a miss so the array port stays read-only
                    stall_c = 1'b1;
                    if (READ_WAIT > 0) begin
                        state_d = RD_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        rd_en   = 1'b1;
                        state_d = RD_DONE;
                    end
                end else begin
                    mem_we     = wb_valid_q;
                    wb_valid_d = 1'b0;
                end
            end
            RD_WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    rd_en   = 1'b1;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdata_d = rd_en ? mem[idx] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            wb_valid_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            wb_valid_q <= wb_valid_d;
`ifdef DMEM_MISALIGN_TRAP_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    // Buffer payload and array carry no reset; every array write is a drain of the buffer.
    always_ff @(posedge clk) begin
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
        if (reset && mem_we) mem[wb_addr_q] <= wb_data_q;
    end

    assign mem_stall   = reset & stall_c;
    assign memreaddata = reset ? rdata_out : '0;
    assign wb_pending  = wb_valid_q;

endmodule
